// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing constants
package uart_pkg;

  localparam int DIV_WIDTH_DEFAULT = 16;
  localparam int MIN_DIV           = 2;

  // Divisors for a 50 MHz clock and 16x oversampling, rounded
  localparam int DIV_9600   = 326;
  localparam int DIV_19200  = 163;
  localparam int DIV_115200 = 27;

  localparam int DEFAULT_DIV = DIV_9600;

endpackage

// File: rtl/baud_tick_counter.sv
// rtl/baud_tick_counter.sv - prescaler plus oversample counter for one timing channel
module baud_tick_counter #(
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 sample_tick_o,
  output logic                 mid_tick_o,
  output logic                 end_tick_o
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_WIDTH-1:0] prescale_q, prescale_d, prescale_inc;
  logic [OS_W-1:0]      os_q, os_d;
  logic                 sample_q, sample_d;
  logic                 mid_q, mid_d;
  logic                 end_q, end_d;
  logic                 wrap;

  // Increment-then-compare keeps the wrap test free of a subtractor
  assign prescale_inc = prescale_q + DIV_WIDTH'(1);
  assign wrap         = (prescale_inc == div_i);

  always_comb begin
    prescale_d = '0;
    os_d       = '0;
    sample_d   = 1'b0;
    mid_d      = 1'b0;
    end_d      = 1'b0;
    if (enable_i) begin
      if (wrap) begin
        os_d     = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
        sample_d = 1'b1;
        mid_d    = (os_q == OS_MID);
        end_d    = (os_q == OS_LAST);
      end else begin
        prescale_d = prescale_inc;
        os_d       = os_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
      os_q       <= '0;
      sample_q   <= 1'b0;
      mid_q      <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      os_q       <= os_d;
      sample_q   <= sample_d;
      mid_q      <= mid_d;
      end_q      <= end_d;
    end
  end

  assign sample_tick_o = sample_q;
  assign mid_tick_o    = mid_q;
  assign end_tick_o    = end_q;

endmodule

// File: rtl/uart_baud_generator.sv
// rtl/uart_baud_generator.sv - TX/RX baud tick generator with deferred divisor reload
module uart_baud_generator
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH   = DIV_WIDTH_DEFAULT,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 divisorLoad,
  input  logic                 txEnable,
  input  logic                 rxEnable,
  output logic                 txBitTick,
  output logic                 rxSampleTick,
  output logic                 rxMidBit,
  output logic                 rxBitEnd,
  output logic                 divPending,
  output logic                 divError
);

  logic [DIV_WIDTH-1:0] active_div_q;
  logic [DIV_WIDTH-1:0] pending_div_q;
  logic                 div_pending_q;
  logic                 div_error_q;
  logic                 load_bad;
  logic                 load_ok;
  logic                 tx_sample_unused;
  logic                 tx_mid_unused;

  assign load_bad = divisorLoad && (divisor < DIV_WIDTH'(MIN_DIV));
  assign load_ok  = divisorLoad && !load_bad;

  // A fresh accepted load takes priority over applying the older pending value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_div_q  <= DIV_WIDTH'(DEFAULT_DIV);
      pending_div_q <= '0;
      div_pending_q <= 1'b0;
      div_error_q   <= 1'b0;
    end else begin
      div_error_q <= load_bad;
      if (load_ok) begin
        pending_div_q <= divisor;
        div_pending_q <= 1'b1;
      end else if (div_pending_q && !txEnable && !rxEnable) begin
        active_div_q  <= pending_div_q;
        div_pending_q <= 1'b0;
      end
    end
  end

  baud_tick_counter #(
    .DIV_WIDTH  (DIV_WIDTH),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tx_counter (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (txEnable),
    .div_i         (active_div_q),
    .sample_tick_o (tx_sample_unused),
    .mid_tick_o    (tx_mid_unused),
    .end_tick_o    (txBitTick)
  );

  baud_tick_counter #(
    .DIV_WIDTH  (DIV_WIDTH),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_rx_counter (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (rxEnable),
    .div_i         (active_div_q),
    .sample_tick_o (rxSampleTick),
    .mid_tick_o    (rxMidBit),
    .end_tick_o    (rxBitEnd)
  );

  assign divPending = div_pending_q;
  assign divError   = div_error_q;

endmodule

// File: tb/tb_uart_baud_generator.sv
// tb/tb_uart_baud_generator.sv - randomized bench against an edge-counting reference model
module tb_uart_baud_generator;

  localparam int DW   = 16;
  localparam int OS   = 4;
  localparam int DDEF = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] divisor = '0;
  logic          divisorLoad = 1'b0;
  logic          txEnable = 1'b0;
  logic          rxEnable = 1'b0;
  logic          txBitTick, rxSampleTick, rxMidBit, rxBitEnd, divPending, divError;

  uart_baud_generator #(
    .DIV_WIDTH   (DW),
    .OVERSAMPLE  (OS),
    .DEFAULT_DIV (DDEF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .divisor      (divisor),
    .divisorLoad  (divisorLoad),
    .txEnable     (txEnable),
    .rxEnable     (rxEnable),
    .txBitTick    (txBitTick),
    .rxSampleTick (rxSampleTick),
    .rxMidBit     (rxMidBit),
    .rxBitEnd     (rxBitEnd),
    .divPending   (divPending),
    .divError     (divError)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: edges elapsed since each channel was enabled, plus divisor bookkeeping
  int tx_n, rx_n, act_div, pend_div;
  bit pend, e_tx, e_smp, e_mid, e_end, e_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    tx_n = 0; rx_n = 0; act_div = DDEF; pend_div = 0; pend = 0;
    e_tx = 0; e_smp = 0; e_mid = 0; e_end = 0; e_err = 0;
  endtask

  task automatic model_edge();
    int bit_len;
    bit_len = act_div * OS;
    e_err = divisorLoad && (int'(divisor) < 2);
    if (txEnable) begin
      tx_n++;
      e_tx = (tx_n % bit_len) == 0;
    end else begin
      tx_n = 0; e_tx = 0;
    end
    if (rxEnable) begin
      rx_n++;
      e_smp = (rx_n % act_div) == 0;
      e_mid = (rx_n % bit_len) == bit_len / 2;
      e_end = (rx_n % bit_len) == 0;
    end else begin
      rx_n = 0; e_smp = 0; e_mid = 0; e_end = 0;
    end
    if (divisorLoad && int'(divisor) >= 2) begin
      pend_div = int'(divisor); pend = 1;
    end else if (pend && !txEnable && !rxEnable) begin
      act_div = pend_div; pend = 0;
    end
  endtask

  task automatic compare_all();
    check("txBitTick", 32'(txBitTick), 32'(e_tx));
    check("rxSampleTick", 32'(rxSampleTick), 32'(e_smp));
    check("rxMidBit", 32'(rxMidBit), 32'(e_mid));
    check("rxBitEnd", 32'(rxBitEnd), 32'(e_end));
    check("divPending", 32'(divPending), 32'(pend));
    check("divError", 32'(divError), 32'(e_err));
  endtask

  task automatic step(input bit t, input bit r, input bit l, input int d);
    txEnable = t; rxEnable = r; divisorLoad = l; divisor = DW'(d);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input bit t, input bit r, input int cycles);
    for (int i = 0; i < cycles; i++) step(t, r, 1'b0, 0);
  endtask

  bit r_tx, r_rx;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    run(1, 0, 50);
    run(0, 0, 2);
    run(0, 1, 36);

    run(0, 0, 2);
    run(0, 1, 10);
    run(0, 0, 3);
    run(0, 1, 20);

    run(0, 0, 2);
    run(1, 0, 5);
    step(1, 0, 1, 6);
    run(1, 0, 40);
    run(0, 0, 2);
    run(1, 0, 50);

    run(0, 0, 2);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    run(1, 0, 3);
    step(1, 0, 1, 5);
    run(1, 0, 4);
    step(1, 0, 1, 7);
    run(1, 0, 4);
    run(0, 0, 2);
    run(1, 1, 60);

    run(0, 0, 2);
    step(0, 0, 1, 9);
    step(0, 0, 1, 3);
    run(0, 0, 2);

    r_tx = 0; r_rx = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) r_tx = ~r_tx;
      if ($urandom_range(39) == 0) r_rx = ~r_rx;
      step(r_tx, r_rx, $urandom_range(24) == 0, int'($urandom_range(9)));
    end

    run(0, 0, 2);
    step(0, 0, 1, 8);
    run(1, 1, 7);
    txEnable = 1'b1; rxEnable = 1'b1; divisorLoad = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_txBitTick", 32'(txBitTick), 32'd0);
    check("rst_rxSampleTick", 32'(rxSampleTick), 32'd0);
    check("rst_rxMidBit", 32'(rxMidBit), 32'd0);
    check("rst_rxBitEnd", 32'(rxBitEnd), 32'd0);
    check("rst_divPending", 32'(divPending), 32'd0);
    check("rst_divError", 32'(divError), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 1, 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_baud_generator.md
Name: uart_baud_generator

Overview:
Parametrised baud-rate tick generator for the RS-232 UART controller, replacing the fixed-divisor, single-channel timing block. It provides independent TX and RX timing channels from one runtime-programmable divisor. The RX channel adds oversampled sample ticks plus mid-bit and bit-end strobes. Divisor changes are deferred safely until both channels are idle.

Parameters:
DIV_WIDTH, 16, width of the divisor (clock cycles per oversample tick)
OVERSAMPLE, 16, oversample ticks per bit; even, >= 4
DEFAULT_DIV, 326, active divisor after reset (50 MHz / (9600*16), rounded); must be >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
divisor  in  DIV_WIDTH  new divisor value, sampled only when divisorLoad=1
divisorLoad  in  1  one-cycle request to load divisor
txEnable  in  1  level; TX channel runs while high
rxEnable  in  1  level; RX channel runs while high, rise aligned to detected start bit
txBitTick  out  1  one-cycle pulse at each TX bit boundary
rxSampleTick  out  1  one-cycle pulse per oversample tick
rxMidBit  out  1  one-cycle pulse at RX bit centre
rxBitEnd  out  1  one-cycle pulse at RX bit end
divPending  out  1  high while an accepted load awaits application
divError  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (async, rst_n=0): activeDiv=DEFAULT_DIV, pendingDiv=0, all counters 0, all outputs 0. Mid-operation reset aborts immediately; both channels restart from 0 after release.
- Notation: D=activeDiv, O=OVERSAMPLE. Edge 1 is the first rising edge at which the channel enable is sampled high.
- Each channel has a prescaler (0..D-1) and an oversample counter (0..O-1). Both counters are DIV_WIDTH and clog2(O) bits wide; no arithmetic beyond compare and increment.
- Enable low: the channel's counters clear to 0 at the next edge. Its outputs are 0 in the following cycle. No pulse is ever emitted in the cycle after enable is sampled low.
- TX: txBitTick is high for exactly one cycle following edges D*O, 2*D*O, ... while txEnable stays high.
- RX rxSampleTick: high for one cycle following edges D, 2D, 3D, ...
- RX rxMidBit: coincides with the (O/2)-th sample tick of each bit, i.e. following edge D*O/2 + k*D*O.
- RX rxBitEnd: coincides with the O-th sample tick, i.e. following edge k*D*O. rxMidBit and rxBitEnd are never high together.
- Divisor load, rejection: a request with divisor < 2 is rejected. divError pulses for 1 cycle following that edge. pendingDiv and divPending are unchanged.
- Divisor load, acceptance: otherwise pendingDiv <= divisor and divPending <= 1. A later load overwrites an earlier pending one (last wins).
- Divisor apply: at any edge where divPending=1 and txEnable=0 and rxEnable=0 are all sampled, activeDiv <= pendingDiv and divPending <= 0.
- Divisor load while idle: divisorLoad with both enables low is captured at edge t and applied at edge t+1. divPending is high for exactly one cycle.
- Simultaneous load and apply edge: the new load wins. pendingDiv takes the new value, divPending stays 1, and the apply happens on the next idle edge.
- Running channels always use the D that was active when they started. activeDiv never changes while either enable is high.

Decomposition:
- Shared package (uart_pkg): DEFAULT_DIV constant, baud-divisor constants for 9600/19200/115200 at 50 MHz, and the DIV_WIDTH default.
- One natural sub-module: baud_tick_counter. It holds the prescaler, the oversample counter and enable-clear logic, and outputs a sample tick, mid tick and end tick.
- It is instantiated twice: TX uses only the end tick, RX uses all three.
- The top level holds the divisor register, the pending/apply logic and the error handling.

Test Plan:
- Reset: DEFAULT_DIV=4, OVERSAMPLE=4, txEnable=1 from edge 1. txBitTick pulses after edges 16, 32, 48, is 1 cycle wide, and stays 0 elsewhere.
- RX ticks: D=4, O=4, rxEnable=1. rxSampleTick follows edges 4, 8, 12, 16. rxMidBit follows edge 8, rxBitEnd follows edge 16, then the pattern repeats with period 16.
- Enable drop: drop rxEnable after edge 10, re-raise 3 cycles later. No pulses occur while low. The next rxMidBit comes 8 edges after the re-rise edge, not resuming the old phase.
- Deferred load: while txEnable=1, load divisor=6. divPending=1 and TX period stays 16. After txEnable=0 the divisor applies on the next edge. Re-enable gives a TX period of 24.
- Rejection and overwrite: load divisor=1, then divError pulses and divPending=0. Load 5 then 7 while running, and the applied value is 7.
- Async reset mid-bit: assert rst_n=0 between clock edges. All outputs drop immediately, without waiting for a clock edge. activeDiv returns to 4 and divPending=0.
